// File: rtl/line_fifo_reader.sv
// Read-side controller for an 8-bit first-word-fall-through line FIFO: pops
// fixed-length lines and streams them as valid/ready bytes with SOL/EOL marks.
module line_fifo_reader #(
  parameter int LEN_W      = 15,
  parameter int NLINE_W    = 16,
  parameter int GAP_CYCLES = 4,
  parameter int STALL_MAX  = 1024
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [LEN_W-1:0]   line_len,
  input  logic [NLINE_W-1:0] line_num,
  input  logic [7:0]         fifo_dout,
  input  logic               fifo_empty,
  input  logic               fifo_underflow,
  output logic               fifo_rd_en,
  output logic [7:0]         px_data,
  output logic               px_valid,
  input  logic               px_ready,
  output logic               px_sol,
  output logic               px_eol,
  output logic               busy,
  output logic               done,
  output logic               err_stall,
  output logic               err_uflow
);

  localparam int GAP_W   = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int STALL_W = (STALL_MAX > 1) ? $clog2(STALL_MAX) : 1;
  localparam logic [GAP_W-1:0]   GAP_LAST   = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'((STALL_MAX > 0) ? STALL_MAX - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_GAP    = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t               r_state;
  logic [LEN_W-1:0]     r_len;
  logic [NLINE_W-1:0]   r_num;
  logic [LEN_W-1:0]     r_issue;
  logic [NLINE_W-1:0]   r_row;
  logic [GAP_W-1:0]     r_gap;
  logic [STALL_W-1:0]   r_stall;
  logic [7:0]           r_px_data;
  logic                 r_px_valid;
  logic                 r_px_sol;
  logic                 r_px_eol;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_err_stall;
  logic                 r_err_uflow;

  logic w_can_load;
  logic w_line_open;
  logic w_rd_en;
  logic w_eol_acc;
  logic w_last_row;
  logic w_stall_hit;
  logic w_uflow_hit;
  logic w_abort;

  // Issue count reaches r_len exactly once per line; LEN_W bits hold 2^LEN_W-1 without wrapping.
  assign w_can_load  = ~r_px_valid | px_ready;
  assign w_line_open = (r_issue < r_len);
  assign w_rd_en     = (r_state == S_STREAM) & ~fifo_empty & w_can_load & w_line_open;
  assign w_eol_acc   = r_px_valid & px_ready & r_px_eol;
  assign w_last_row  = (r_row == (r_num - NLINE_W'(1)));
  assign w_stall_hit = (r_state == S_STREAM) & w_line_open & fifo_empty & (r_stall == STALL_LAST);
  assign w_uflow_hit = ((r_state == S_STREAM) | (r_state == S_GAP)) & fifo_underflow;
  assign w_abort     = w_stall_hit | w_uflow_hit;

  assign fifo_rd_en = w_rd_en;
  assign px_data    = r_px_data;
  assign px_valid   = r_px_valid;
  assign px_sol     = r_px_sol;
  assign px_eol     = r_px_eol;
  assign busy       = r_busy;
  assign done       = r_done;
  assign err_stall  = r_err_stall;
  assign err_uflow  = r_err_uflow;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_len       <= '0;
      r_num       <= '0;
      r_issue     <= '0;
      r_row       <= '0;
      r_gap       <= '0;
      r_stall     <= '0;
      r_px_data   <= 8'h00;
      r_px_valid  <= 1'b0;
      r_px_sol    <= 1'b0;
      r_px_eol    <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err_stall <= 1'b0;
      r_err_uflow <= 1'b0;
    end else begin
      r_done <= 1'b0;

      if (w_abort) begin
        r_px_valid <= 1'b0;
        r_px_sol   <= 1'b0;
        r_px_eol   <= 1'b0;
      end else if (w_rd_en) begin
        r_px_data  <= fifo_dout;
        r_px_valid <= 1'b1;
        r_px_sol   <= (r_issue == '0);
        r_px_eol   <= (r_issue == (r_len - LEN_W'(1)));
      end else if (px_ready) begin
        r_px_valid <= 1'b0;
      end

      // Starvation timer only runs while the current line still owes bytes.
      if (w_rd_en) begin
        r_issue <= r_issue + LEN_W'(1);
        r_stall <= '0;
      end else if ((r_state == S_STREAM) && w_line_open && fifo_empty) begin
        r_stall <= r_stall + STALL_W'(1);
      end

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_len       <= (line_len == '0) ? LEN_W'(1) : line_len;
            r_num       <= (line_num == '0) ? NLINE_W'(1) : line_num;
            r_issue     <= '0;
            r_row       <= '0;
            r_stall     <= '0;
            r_err_stall <= 1'b0;
            r_err_uflow <= 1'b0;
            r_busy      <= 1'b1;
            r_state     <= S_STREAM;
          end
        end
        S_STREAM: begin
          if (w_eol_acc) begin
            if (w_last_row) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
            end else if (GAP_CYCLES == 0) begin
              r_row   <= r_row + NLINE_W'(1);
              r_issue <= '0;
            end else begin
              r_gap   <= '0;
              r_state <= S_GAP;
            end
          end
        end
        S_GAP: begin
          if (r_gap == GAP_LAST) begin
            r_row   <= r_row + NLINE_W'(1);
            r_issue <= '0;
            r_state <= S_STREAM;
          end else begin
            r_gap <= r_gap + GAP_W'(1);
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase

      // Abort overrides any transition chosen above; both causes may latch together.
      if (w_abort) begin
        r_state     <= S_IDLE;
        r_busy      <= 1'b0;
        r_done      <= 1'b0;
        r_err_stall <= r_err_stall | w_stall_hit;
        r_err_uflow <= r_err_uflow | w_uflow_hit;
      end
    end
  end

endmodule

// File: tb/tb_line_fifo_reader.sv
// Bench for line_fifo_reader: FIFO and sink models plus a beat-level expected
// stream built from line length/count arithmetic.
`timescale 1ns/1ps
module tb_line_fifo_reader;

  localparam int LEN_W = 15;
  localparam int NLINE_W = 16;
  localparam int GAP = 4;
  localparam int SMAX = 16;

  typedef struct packed {
    logic [7:0] d;
    logic       sol;
    logic       eol;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic [LEN_W-1:0]   line_len = '0;
  logic [NLINE_W-1:0] line_num = '0;
  logic [7:0]         fifo_dout = 8'h00;
  logic               fifo_empty = 1'b1;
  logic               fifo_underflow = 1'b0;
  logic               fifo_rd_en;
  logic [7:0]         px_data;
  logic               px_valid;
  logic               px_ready = 1'b1;
  logic               px_sol;
  logic               px_eol;
  logic               busy;
  logic               done;
  logic               err_stall;
  logic               err_uflow;

  line_fifo_reader #(.LEN_W(LEN_W), .NLINE_W(NLINE_W), .GAP_CYCLES(GAP), .STALL_MAX(SMAX)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .line_len(line_len), .line_num(line_num),
    .fifo_dout(fifo_dout), .fifo_empty(fifo_empty), .fifo_underflow(fifo_underflow),
    .fifo_rd_en(fifo_rd_en), .px_data(px_data), .px_valid(px_valid), .px_ready(px_ready),
    .px_sol(px_sol), .px_eol(px_eol), .busy(busy), .done(done),
    .err_stall(err_stall), .err_uflow(err_uflow)
  );

  logic [7:0] fq[$];
  beat_t      exp_q[$];
  beat_t      acc_log[$];
  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  int rd_cnt = 0;
  int done_cnt = 0;
  int last_acc_cyc = 0;
  int last_eol_cyc = -1;
  int last_pop_cyc = 0;
  int stall_rise_cyc = 0;
  int frame_c0 = 0;
  int ready_mode = 0;
  int rdy_k = 0;
  logic  pop_req = 1'b0;
  logic  prev_hold = 1'b0;
  logic  prev_stall = 1'b0;
  beat_t prev_beat;
  beat_t mon_e;

  task automatic chk(input string name, input longint act, input longint expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  // FIFO head and sink readiness change just after each rising edge.
  always @(posedge clk) begin
    #1;
    if (pop_req && fq.size() > 0) void'(fq.pop_front());
    fifo_empty = (fq.size() == 0);
    fifo_dout = (fq.size() > 0) ? fq[0] : 8'h00;
    rdy_k++;
    px_ready = (ready_mode == 0) ? 1'b1 : ((rdy_k % 4 == 0) || (rdy_k % 4 == 3));
  end

  // Compare process: protocol invariants and accepted beats against the model.
  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      chk("rd_en_while_empty", fifo_rd_en & fifo_empty, 0);
      chk("rd_en_while_stalled", fifo_rd_en & px_valid & ~px_ready, 0);
      if (prev_hold) begin
        chk("hold_valid", px_valid, 1);
        chk("hold_beat", {px_data, px_sol, px_eol}, prev_beat);
      end
      if (fifo_rd_en) begin
        rd_cnt++;
        last_pop_cyc = cyc;
      end
      if (px_valid && px_ready) begin
        if (exp_q.size() == 0) begin
          chk("extra_beat", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("beat", {px_data, px_sol, px_eol}, mon_e);
        end
        if (px_sol && ready_mode == 0 && last_eol_cyc > frame_c0)
          chk("gap_len", cyc - last_eol_cyc, GAP + 2);
        if (!px_sol && ready_mode == 0)
          chk("throughput", cyc - last_acc_cyc, 1);
        acc_log.push_back({px_data, px_sol, px_eol});
        last_acc_cyc = cyc;
        if (px_eol) last_eol_cyc = cyc;
      end
      if (done) begin
        done_cnt++;
        chk("done_after_eol", cyc - last_eol_cyc, 1);
        chk("done_busy", busy, 0);
        chk("done_model_empty", exp_q.size(), 0);
      end
      if (err_stall && !prev_stall) stall_rise_cyc = cyc;
      prev_stall = err_stall;
      prev_hold = px_valid & ~px_ready;
      prev_beat = {px_data, px_sol, px_eol};
      pop_req = fifo_rd_en;
    end else begin
      prev_hold = 1'b0;
      prev_stall = 1'b0;
      pop_req = 1'b0;
    end
  end

  task automatic load(input int len, input int num, input int nbytes, input int base);
    for (int i = 0; i < nbytes; i++) fq.push_back(8'(base + i));
    for (int i = 0; i < len * num; i++)
      exp_q.push_back({8'(base + i), (i % len) == 0, (i % len) == (len - 1)});
    repeat (2) @(negedge clk);
  endtask

  task automatic start_frame(input int len, input int num);
    @(posedge clk); #2;
    frame_c0 = cyc;
    line_len = LEN_W'(len);
    line_num = NLINE_W'(num);
    start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    for (int i = 0; i < budget && busy; i++) @(negedge clk);
    chk(name, busy, 0);
    repeat (2) @(negedge clk);
  endtask

  int rd0, dn0, a0;

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_valid", px_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_rd_en", fifo_rd_en, 0);
    @(posedge clk); #3 rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_idle", {busy, done, err_stall, err_uflow, px_valid}, 0);

    // Two lines of four, sink always ready.
    ready_mode = 0;
    rd0 = rd_cnt; dn0 = done_cnt; a0 = acc_log.size();
    load(4, 2, 8, 8'h10);
    start_frame(4, 2);
    wait_idle(200, "t1_timeout");
    chk("t1_rd_count", rd_cnt - rd0, 8);
    chk("t1_done_count", done_cnt - dn0, 1);
    chk("t1_first", acc_log[a0], {8'h10, 1'b1, 1'b0});
    chk("t1_eol0", acc_log[a0 + 3], {8'h13, 1'b0, 1'b1});
    chk("t1_sol1", acc_log[a0 + 4], {8'h14, 1'b1, 1'b0});
    chk("t1_last", acc_log[a0 + 7], {8'h17, 1'b0, 1'b1});
    chk("t1_errs", {err_stall, err_uflow}, 0);

    // Backpressure pattern 1,0,0,1 plus a start while busy that must be ignored.
    ready_mode = 1;
    rd0 = rd_cnt; dn0 = done_cnt;
    load(4, 2, 8, 8'h20);
    start_frame(4, 2);
    repeat (3) @(negedge clk);
    start_frame(1, 1);
    wait_idle(300, "t2_timeout");
    chk("t2_rd_count", rd_cnt - rd0, 8);
    chk("t2_done_count", done_cnt - dn0, 1);
    chk("t2_model_empty", exp_q.size(), 0);
    ready_mode = 0;

    // Single-byte lines.
    rd0 = rd_cnt; dn0 = done_cnt; a0 = acc_log.size();
    load(1, 3, 3, 8'hA0);
    start_frame(1, 3);
    wait_idle(200, "t3_timeout");
    chk("t3_rd_count", rd_cnt - rd0, 3);
    chk("t3_done_count", done_cnt - dn0, 1);
    chk("t3_beat0", acc_log[a0], {8'hA0, 1'b1, 1'b1});
    chk("t3_beat2", acc_log[a0 + 2], {8'hA2, 1'b1, 1'b1});

    // Starvation: 8-byte line with only 5 bytes available.
    rd0 = rd_cnt; dn0 = done_cnt;
    load(8, 1, 5, 8'h30);
    start_frame(8, 1);
    wait_idle(200, "t4_timeout");
    chk("t4_err_stall", err_stall, 1);
    chk("t4_err_uflow", err_uflow, 0);
    chk("t4_valid", px_valid, 0);
    chk("t4_rd_count", rd_cnt - rd0, 5);
    chk("t4_no_done", done_cnt - dn0, 0);
    chk("t4_stall_delay", stall_rise_cyc - last_pop_cyc, 17);
    chk("t4_model_left", exp_q.size(), 3);
    exp_q.delete();
    rd0 = rd_cnt; dn0 = done_cnt;
    load(2, 1, 2, 8'h40);
    start_frame(2, 1);
    @(negedge clk);
    chk("t4_restart_clears", err_stall, 0);
    wait_idle(200, "t4b_timeout");
    chk("t4b_done_count", done_cnt - dn0, 1);
    chk("t4b_rd_count", rd_cnt - rd0, 2);

    // Underflow mid-line.
    dn0 = done_cnt;
    load(4, 1, 2, 8'h50);
    start_frame(4, 1);
    repeat (5) @(negedge clk);
    chk("t5_busy_before", busy, 1);
    @(posedge clk); #2 fifo_underflow = 1'b1;
    @(negedge clk);
    chk("t5_uflow_not_yet", err_uflow, 0);
    @(negedge clk);
    chk("t5_err_uflow", err_uflow, 1);
    chk("t5_valid", px_valid, 0);
    chk("t5_busy", busy, 0);
    chk("t5_err_stall", err_stall, 0);
    @(posedge clk); #2 fifo_underflow = 1'b0;
    repeat (3) @(negedge clk);
    chk("t5_no_done", done_cnt - dn0, 0);
    chk("t5_model_left", exp_q.size(), 2);
    exp_q.delete();

    // Asynchronous reset mid-frame.
    load(4, 2, 8, 8'h60);
    start_frame(4, 2);
    repeat (3) @(negedge clk);
    chk("t6_pre_valid", px_valid, 1);
    @(posedge clk); #3 rst_n = 1'b0;
    #1;
    chk("t6_outputs_zero", {px_data, px_valid, px_sol, px_eol, busy, done, err_stall, err_uflow, fifo_rd_en}, 0);
    fq.delete();
    exp_q.delete();
    @(posedge clk); #3 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("t6_idle_after", {busy, px_valid}, 0);

    // Maximum line length, one line.
    rd0 = rd_cnt; dn0 = done_cnt; a0 = acc_log.size();
    load(32767, 1, 32767, 0);
    start_frame(32767, 1);
    wait_idle(40000, "t7_timeout");
    chk("t7_rd_count", rd_cnt - rd0, 32767);
    chk("t7_done_count", done_cnt - dn0, 1);
    chk("t7_first", acc_log[a0], {8'h00, 1'b1, 1'b0});
    chk("t7_before_last", acc_log[a0 + 32765], {8'hFD, 1'b0, 1'b0});
    chk("t7_last", acc_log[a0 + 32766], {8'hFE, 1'b0, 1'b1});
    chk("t7_beats", acc_log.size() - a0, 32767);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/line_fifo_reader.md
Name: line_fifo_reader

Overview:
Read-side controller for the 8-bit first-word-fall-through line FIFO. It pops a programmed number of lines of programmed length and presents them as a valid/ready byte stream. Each byte carries start-of-line and end-of-line markers, and a fixed blanking gap is inserted between lines. Mid-line starvation and FIFO underflow are reported as sticky errors, and either one aborts the frame.

Parameters:
LEN_W, 15, width of line length and column counter (max line 32767 bytes)
NLINE_W, 16, width of line count and row counter
GAP_CYCLES, 4, idle cycles inserted after each line's EOL byte is accepted (0 = none)
STALL_MAX, 1024, consecutive mid-line empty cycles before stall abort

Ports:
clk  in  1  system clock; FIFO read clock is tied to this clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; latches line_len/line_num and begins a frame; ignored while busy
line_len  in  LEN_W  bytes per line, 1..2^LEN_W-1; 0 treated as 1
line_num  in  NLINE_W  lines per frame, 1..2^NLINE_W-1; 0 treated as 1
fifo_dout  in  8  FWFT head data
fifo_empty  in  1  FIFO empty flag
fifo_underflow  in  1  FIFO sticky underflow flag
fifo_rd_en  out  1  pop strobe
px_data  out  8  output byte
px_valid  out  1  output byte valid
px_ready  in  1  downstream accept
px_sol  out  1  first byte of line, qualified by px_valid
px_eol  out  1  last byte of line, qualified by px_valid
busy  out  1  high from start until DONE/abort
done  out  1  one-cycle pulse on frame completion
err_stall  out  1  sticky: starvation timeout
err_uflow  out  1  sticky: fifo_underflow seen while busy

Behaviour:
- Reset values: all outputs 0; FSM=IDLE; counters 0; errors cleared. Errors are also cleared by an accepted start.
- FSM states: IDLE, STREAM, GAP, DONE.
  - IDLE -> STREAM on start; col=0, row=0.
  - STREAM -> GAP when the EOL byte is accepted (px_valid&px_ready&px_eol) and row != line_num-1. Goes directly back to STREAM when GAP_CYCLES=0.
  - STREAM -> DONE when the EOL byte of the last row is accepted.
  - GAP -> STREAM after GAP_CYCLES cycles; row increments and col resets.
  - DONE -> IDLE after one cycle; done=1 in DONE; busy=0 in IDLE and DONE.
- Output stage is a single register. Define can_load = ~px_valid | px_ready.
- fifo_rd_en = (state==STREAM) & ~fifo_empty & can_load & (bytes issued for this line < line_len).
  - fifo_rd_en is combinational.
  - It never asserts while fifo_empty=1.
  - It never pops beyond line_len within a line.
- On fifo_rd_en:
  - px_data<=fifo_dout and px_valid<=1 on the next edge; latency is 1 cycle from pop to valid.
  - px_sol<=(issue count==0); px_eol<=(issue count==line_len-1).
- Otherwise, on px_ready: px_valid<=0.
- px_data, px_sol and px_eol hold stable while px_valid&~px_ready.
- Throughput: 1 byte/cycle with FIFO non-empty and px_ready held high.
- line_len=1: each byte has sol=eol=1.
- Issue counter is LEN_W bits. At line_len=2^LEN_W-1 it reaches max and must not wrap before EOL.
- Stall: in STREAM, a counter increments each cycle that the line is incomplete and fifo_empty=1; it clears on any pop.
  - At STALL_MAX: err_stall<=1, px_valid<=0, FSM->IDLE. No done pulse.
- Underflow: fifo_underflow=1 while busy sets err_uflow<=1 and aborts to IDLE the same way.
- Simultaneous: if the stall limit and underflow occur in the same cycle, both flags are set.
- Start arriving in DONE is ignored; start arriving in the same cycle as an abort is ignored.
- Async reset mid-frame: everything returns to reset values immediately; a FIFO byte already popped is discarded.

Test Plan:
- line_len=4, line_num=2, GAP_CYCLES=4, FIFO preloaded 0x10..0x17, px_ready=1 -> bytes 0x10..0x13 on consecutive cycles with sol on 0x10 and eol on 0x13. Then 4 idle cycles, then 0x14..0x17. Exactly 8 rd_en pulses, done pulse 1 cycle after the 0x17 accept, busy low.
- Same setup, px_ready toggled 1,0,0,1,... -> px_data stable while not ready; no byte lost or duplicated; rd_en never high while px_valid&~px_ready.
- line_len=1, line_num=3 with bytes 0xA0,0xA1,0xA2 -> three beats, each with sol=eol=1; done after the third.
- line_len=8, only 5 bytes supplied, STALL_MAX=16 -> after 16 empty cycles err_stall=1, busy=0, no done, rd_en count=5. Next start clears err_stall.
- fifo_underflow asserted mid-line -> err_uflow=1 next cycle, px_valid=0, busy=0. rst_n pulsed low mid-frame -> all outputs 0 asynchronously.
- line_len=0x7FFF, line_num=1 -> sol on beat 0, eol only on beat 32766, done follows; issue counter never wraps.
